mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1, meaning 1 = memory states wait for mem_ready_i and 0 = ready ignored (single-cycle memory).
REQ-002 SHALL have parameter ENABLE_BNE, default 1, meaning 1 = bne decoded and 0 = bne treated as illegal.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port op_i6  input  6  opcode field of the instruction register.
REQ-006 SHALL have port funct_i6  input  6  funct field of the instruction register.
REQ-007 SHALL have port zero_i  input  1  ALU zero flag.
REQ-008 SHALL have port mem_ready_i  input  1  memory access complete this cycle.
REQ-009 SHALL have outputs, all 1 bit: iord_o, ir_write_o, mem_write_o, mem_to_reg_o, reg_dst_rtrd_o, enable_wreg_o, alu_src_a_o, apply_shift_o, pc_en_o, illegal_o.
REQ-010 SHALL have 2-bit outputs alu_src_b_o2, pc_src_o2, alu_alt_ctrl_o2, and a 4-bit output state_o4 for debug.

Function
REQ-011 SHALL be a Moore FSM with 12 states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-012 SHALL decode the following opcodes: R 000000; lw 100011; sw 101011; beq 000100; bne 000101; addi 001000; j 000010.
REQ-013 SHALL use these encodings: alu_alt_ctrl 00 add, 01 sub, 10 use funct; alu_src_b 00 regB, 01 const 4, 10 signimm, 11 signimm<<2; pc_src 00 ALU result, 01 ALUOut, 10 jump target.
REQ-014 FETCH SHALL assert iord=0, alu_src_a=0, alu_src_b=01, alu=00, pc_src=00, and assert ir_write and pc_write only in the cycle the memory completes.
REQ-015 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu=00, and go to MEMADR (lw/sw), EXECUTE (R), BRANCH (beq/bne), ADDIEX (addi) or JUMP (j).
REQ-016 DECODE SHALL, on an illegal opcode, pulse illegal_o for one cycle and go to FETCH.
REQ-017 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, alu=00, then go to MEMRD (lw) or MEMWR (sw).
REQ-018 MEMRD SHALL drive iord=1; MEMWB SHALL drive reg_dst_rtrd=0, mem_to_reg=1, enable_wreg=1.
REQ-019 MEMWR SHALL drive iord=1 and mem_write=1.
REQ-020 EXECUTE SHALL drive alu_src_a=1, alu_src_b=00, alu=10, with apply_shift=1 when funct is 000000 (sll) or 000010 (srl).
REQ-021 ALUWB SHALL drive reg_dst_rtrd=1, mem_to_reg=0, enable_wreg=1.
REQ-022 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu=01, pc_src=01.
REQ-023 pc_en_o SHALL equal pc_write | (beq_branch & zero_i) | (bne_branch & !zero_i), combinationally.
REQ-024 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu=00; ADDIWB SHALL drive reg_dst_rtrd=0, mem_to_reg=0, enable_wreg=1.
REQ-025 JUMP SHALL drive pc_src=10 and pc_write=1.
REQ-026 MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP SHALL return to FETCH.
REQ-027 With MEM_HANDSHAKE=1, FETCH, MEMRD and MEMWR SHALL hold while mem_ready_i=0, keeping addresses stable.
REQ-028 With MEM_HANDSHAKE=1, mem_write SHALL stay high throughout a MEMWR hold.
REQ-029 Control signals not listed for a state SHALL be 0.
REQ-030 Latency with ready tied high SHALL be: lw 5 cycles; sw, R and addi 4; beq, bne and j 3.

Reset
REQ-031 rst_ni low SHALL asynchronously force state FETCH.
REQ-032 While rst_ni is low, ir_write, pc_en, mem_write, enable_wreg and illegal SHALL be 0; other outputs SHALL take FETCH values.
REQ-033 Reset asserted mid-instruction SHALL abandon it; the first rising edge after release SHALL evaluate FETCH.

Structure
REQ-034 The package mc_pkg SHALL hold the state_t enum (4-bit), opcode/funct constants, and the alu_src_b, pc_src and alu_alt_ctrl encodings.
REQ-035 The block SHALL use one sub-module, mc_main_fsm (state register, next-state logic, output decode); the top SHALL add pc_en and reset gating.

Verification
REQ-036 lw with ready high -> states F,D,MA,MR,MWB; enable_wreg=1 with mem_to_reg=1 only in cycle 5.
REQ-037 beq with zero_i=1 -> pc_en=1 in BRANCH; bne with zero_i=1 -> pc_en=0; with ENABLE_BNE=0, bne -> illegal_o pulse, next FETCH.
REQ-038 sw with mem_ready_i low for 3 cycles in MEMWR -> mem_write held 4 cycles, FETCH follows the ready cycle.
REQ-039 R-type funct 000010 -> apply_shift=1 and alu=10 in EXECUTE; funct 100000 -> apply_shift=0.
REQ-040 rst_ni dropped in MEMRD between clock edges -> immediate FETCH, all write enables 0, state_o4 = FETCH code.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller.
// State codes are visible on state_o4, so their values are fixed here.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/mc_main_fsm.sv
// Purpose: state register, next-state logic and Moore output decode of the controller.
// Latency: outputs decode the current state combinationally; one state per clk_i.
// Backpressure: FETCH/MEMRD/MEMWR hold while mem_ready=0 when MEM_HANDSHAKE is set.
module mc_main_fsm
    import mc_pkg::*;
#(
    parameter int unsigned MEM_HANDSHAKE = 1,
    parameter int unsigned ENABLE_BNE    = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic [3:0] state,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst_rtrd,
    output logic       enable_wreg,
    output logic       alu_src_a,
    output logic       apply_shift,
    output logic       pc_write,
    output logic       beq_branch,
    output logic       bne_branch,
    output logic       illegal,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [1:0] alu_alt_ctrl
);

    state_t state_q;
    state_t state_d;
    logic   mem_done;

    assign mem_done = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign state    = state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        iord         = 1'b0;
        ir_write     = 1'b0;
        mem_write    = 1'b0;
        mem_to_reg   = 1'b0;
        reg_dst_rtrd = 1'b0;
        enable_wreg  = 1'b0;
        alu_src_a    = 1'b0;
        apply_shift  = 1'b0;
        pc_write     = 1'b0;
        beq_branch   = 1'b0;
        bne_branch   = 1'b0;
        illegal      = 1'b0;
        alu_src_b    = SRCB_REGB;
        pc_src       = PC_ALU;
        alu_alt_ctrl = ALU_ADD;
        case (state_q)
            FETCH: begin
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_done;
                pc_write  = mem_done;
                if (mem_done) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                state_d   = FETCH;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    OP_BNE: begin
                        if (ENABLE_BNE != 0) state_d = BRANCH;
                        else                 illegal = 1'b1;
                    end
                    default:      illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord = 1'b1;
                if (mem_done) state_d = MEMWB;
            end
            MEMWB: begin
                mem_to_reg  = 1'b1;
                enable_wreg = 1'b1;
                state_d     = FETCH;
            end
            MEMWR: begin
                // Write strobe stays up for the whole hold so slow memories see a stable request.
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_done) state_d = FETCH;
            end
            EXECUTE: begin
                alu_src_a    = 1'b1;
                alu_alt_ctrl = ALU_FUNCT;
                apply_shift  = (funct == FUNCT_SLL) || (funct == FUNCT_SRL);
                state_d      = ALUWB;
            end
            ALUWB: begin
                reg_dst_rtrd = 1'b1;
                enable_wreg  = 1'b1;
                state_d      = FETCH;
            end
            BRANCH: begin
                alu_src_a    = 1'b1;
                alu_alt_ctrl = ALU_SUB;
                pc_src       = PC_ALUOUT;
                beq_branch   = (op == OP_BEQ);
                bne_branch   = (ENABLE_BNE != 0) && (op == OP_BNE);
                state_d      = FETCH;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                enable_wreg = 1'b1;
                state_d     = FETCH;
            end
            JUMP: begin
                pc_src   = PC_JUMP;
                pc_write = 1'b1;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Purpose: multicycle CPU control unit; FSM plus PC-enable combine and reset gating.
// Latency: lw 5 cycles, sw/R/addi 4, beq/bne/j 3 with memory ready.
// Backpressure: memory states stall on mem_ready_i=0 when MEM_HANDSHAKE=1.
module mc_controller
    import mc_pkg::*;
#(
    parameter int unsigned MEM_HANDSHAKE = 1,
    parameter int unsigned ENABLE_BNE    = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [5:0] op_i6,
    input  logic [5:0] funct_i6,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       iord_o,
    output logic       ir_write_o,
    output logic       mem_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_dst_rtrd_o,
    output logic       enable_wreg_o,
    output logic       alu_src_a_o,
    output logic       apply_shift_o,
    output logic       pc_en_o,
    output logic       illegal_o,
    output logic [1:0] alu_src_b_o2,
    output logic [1:0] pc_src_o2,
    output logic [1:0] alu_alt_ctrl_o2,
    output logic [3:0] state_o4
);

    logic ir_write;
    logic mem_write;
    logic enable_wreg;
    logic illegal;
    logic pc_write;
    logic beq_branch;
    logic bne_branch;

    mc_main_fsm #(
        .MEM_HANDSHAKE (MEM_HANDSHAKE),
        .ENABLE_BNE    (ENABLE_BNE)
    ) u_fsm (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .op           (op_i6),
        .funct        (funct_i6),
        .mem_ready    (mem_ready_i),
        .state        (state_o4),
        .iord         (iord_o),
        .ir_write     (ir_write),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg_o),
        .reg_dst_rtrd (reg_dst_rtrd_o),
        .enable_wreg  (enable_wreg),
        .alu_src_a    (alu_src_a_o),
        .apply_shift  (apply_shift_o),
        .pc_write     (pc_write),
        .beq_branch   (beq_branch),
        .bne_branch   (bne_branch),
        .illegal      (illegal),
        .alu_src_b    (alu_src_b_o2),
        .pc_src       (pc_src_o2),
        .alu_alt_ctrl (alu_alt_ctrl_o2)
    );

    // Side-effecting strobes are masked while reset is held, even though the state is FETCH.
    assign ir_write_o    = rst_ni & ir_write;
    assign mem_write_o   = rst_ni & mem_write;
    assign enable_wreg_o = rst_ni & enable_wreg;
    assign illegal_o     = rst_ni & illegal;
    assign pc_en_o       = rst_ni & (pc_write | (beq_branch & zero_i) | (bne_branch & ~zero_i));

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: expected per-cycle outputs are queued as stimulus is driven.
module tb_mc_controller;
    import mc_pkg::*;

    typedef struct packed {
        logic [3:0] state;
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       enable_wreg;
        logic       alu_src_a;
        logic       apply_shift;
        logic       pc_en;
        logic       illegal;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic [1:0] alu;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst_nb;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       iord, ir_write, mem_write, mem_to_reg, reg_dst, enable_wreg;
    logic       alu_src_a, apply_shift, pc_en, illegal;
    logic [1:0] src_b, pc_src, alu;
    logic [3:0] state;
    logic       iord_n, ir_write_n, mem_write_n, mem_to_reg_n, reg_dst_n, enable_wreg_n;
    logic       alu_src_a_n, apply_shift_n, pc_en_n, illegal_n;
    logic [1:0] src_b_n, pc_src_n, alu_n;
    logic [3:0] state_n;

    outs_t got, got_nb;
    outs_t sb [$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk_i(clk), .rst_ni(rst_n), .op_i6(op), .funct_i6(funct), .zero_i(zero),
        .mem_ready_i(mem_ready), .iord_o(iord), .ir_write_o(ir_write),
        .mem_write_o(mem_write), .mem_to_reg_o(mem_to_reg), .reg_dst_rtrd_o(reg_dst),
        .enable_wreg_o(enable_wreg), .alu_src_a_o(alu_src_a), .apply_shift_o(apply_shift),
        .pc_en_o(pc_en), .illegal_o(illegal), .alu_src_b_o2(src_b), .pc_src_o2(pc_src),
        .alu_alt_ctrl_o2(alu), .state_o4(state)
    );

    mc_controller #(.MEM_HANDSHAKE(1), .ENABLE_BNE(0)) dut_nb (
        .clk_i(clk), .rst_ni(rst_nb), .op_i6(op), .funct_i6(funct), .zero_i(zero),
        .mem_ready_i(mem_ready), .iord_o(iord_n), .ir_write_o(ir_write_n),
        .mem_write_o(mem_write_n), .mem_to_reg_o(mem_to_reg_n), .reg_dst_rtrd_o(reg_dst_n),
        .enable_wreg_o(enable_wreg_n), .alu_src_a_o(alu_src_a_n), .apply_shift_o(apply_shift_n),
        .pc_en_o(pc_en_n), .illegal_o(illegal_n), .alu_src_b_o2(src_b_n), .pc_src_o2(pc_src_n),
        .alu_alt_ctrl_o2(alu_n), .state_o4(state_n)
    );

    assign got = {state, iord, ir_write, mem_write, mem_to_reg, reg_dst, enable_wreg,
                  alu_src_a, apply_shift, pc_en, illegal, src_b, pc_src, alu};
    assign got_nb = {state_n, iord_n, ir_write_n, mem_write_n, mem_to_reg_n, reg_dst_n,
                     enable_wreg_n, alu_src_a_n, apply_shift_n, pc_en_n, illegal_n,
                     src_b_n, pc_src_n, alu_n};

    // Reference behaviour of each state, written from the control table.
    function automatic outs_t exp_of(state_t st, logic [5:0] o, logic [5:0] f,
                                     logic z, logic rdy, bit en_bne);
        outs_t e;
        bit    legal;
        e = '0;
        e.state = st;
        legal = (o == OP_R) || (o == OP_LW) || (o == OP_SW) || (o == OP_BEQ) ||
                (o == OP_ADDI) || (o == OP_J) || ((o == OP_BNE) && en_bne);
        case (st)
            FETCH:   begin e.src_b = 2'b01; e.ir_write = rdy; e.pc_en = rdy; end
            DECODE:  begin e.src_b = 2'b11; e.illegal = !legal; end
            MEMADR:  begin e.alu_src_a = 1'b1; e.src_b = 2'b10; end
            MEMRD:   e.iord = 1'b1;
            MEMWB:   begin e.mem_to_reg = 1'b1; e.enable_wreg = 1'b1; end
            MEMWR:   begin e.iord = 1'b1; e.mem_write = 1'b1; end
            EXECUTE: begin
                e.alu_src_a = 1'b1; e.alu = 2'b10;
                e.apply_shift = (f == 6'b000000) || (f == 6'b000010);
            end
            ALUWB:   begin e.reg_dst = 1'b1; e.enable_wreg = 1'b1; end
            BRANCH:  begin
                e.alu_src_a = 1'b1; e.alu = 2'b01; e.pc_src = 2'b01;
                e.pc_en = ((o == OP_BEQ) && z) || ((o == OP_BNE) && en_bne && !z);
            end
            ADDIEX:  begin e.alu_src_a = 1'b1; e.src_b = 2'b10; end
            ADDIWB:  e.enable_wreg = 1'b1;
            JUMP:    begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic test_reset();
        outs_t e;
        rst_n = 1'b0; rst_nb = 1'b0; mem_ready = 1'b1;
        op = OP_LW; funct = 6'h00; zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sb.push_back(exp_of(FETCH, op, funct, zero, 1'b0, 1'b1));
        sb.push_back(exp_of(FETCH, op, funct, zero, 1'b0, 1'b0));
        e = sb.pop_front();
        checks++;
        if (got !== e) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", got, e); end
        e = sb.pop_front();
        checks++;
        if (got_nb !== e) begin failures++; $display("FAIL reset_outputs_nb got=%h exp=%h", got_nb, e); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        state_t p [5] = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB};
        outs_t e;
        op = OP_LW; funct = 6'h00; zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b1;
            sb.push_back(exp_of(p[i], op, funct, zero, 1'b1, 1'b1));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin failures++; $display("FAIL lw_cycle%0d got=%h exp=%h", i + 1, got, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_wait();
        state_t p [7] = '{FETCH, DECODE, MEMADR, MEMWR, MEMWR, MEMWR, MEMWR};
        logic   r [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        outs_t  e;
        int     wr_cycles = 0;
        op = OP_SW; funct = 6'h00; zero = 1'b1;
        for (int i = 0; i < 7; i++) begin
            mem_ready = r[i];
            sb.push_back(exp_of(p[i], op, funct, zero, r[i], 1'b1));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin failures++; $display("FAIL sw_cycle%0d got=%h exp=%h", i + 1, got, e); end
            if (mem_write === 1'b1) wr_cycles++;
            @(posedge clk); #1;
        end
        checks++;
        if (wr_cycles != 4) begin failures++; $display("FAIL sw_write_len got=%0d exp=4", wr_cycles); end
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== FETCH) begin failures++; $display("FAIL sw_after got=%0d exp=%0d", state, FETCH); end
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        state_t     p [4] = '{FETCH, DECODE, EXECUTE, ALUWB};
        logic [5:0] fn [3] = '{6'b000010, 6'b100000, 6'b000000};
        logic       sh [3] = '{1'b1, 1'b0, 1'b1};
        outs_t      e;
        op = OP_R; zero = 1'b0;
        for (int k = 0; k < 3; k++) begin
            funct = fn[k];
            for (int i = 0; i < 4; i++) begin
                mem_ready = 1'b1;
                sb.push_back(exp_of(p[i], op, funct, zero, 1'b1, 1'b1));
                @(negedge clk);
                e = sb.pop_front();
                checks++;
                if (got !== e) begin
                    failures++; $display("FAIL rtype%0d_cycle%0d got=%h exp=%h", k, i + 1, got, e);
                end
                if (p[i] == EXECUTE) begin
                    checks++;
                    if (apply_shift !== sh[k] || alu !== 2'b10) begin
                        failures++;
                        $display("FAIL rtype%0d_shift got=%b/%b exp=%b/10", k, apply_shift, alu, sh[k]);
                    end
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_branch();
        state_t     p [3] = '{FETCH, DECODE, BRANCH};
        logic [5:0] bo [4] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
        logic       bz [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       bp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        outs_t      e;
        funct = 6'h00;
        for (int k = 0; k < 4; k++) begin
            op = bo[k]; zero = bz[k];
            for (int i = 0; i < 3; i++) begin
                mem_ready = 1'b1;
                sb.push_back(exp_of(p[i], op, funct, zero, 1'b1, 1'b1));
                @(negedge clk);
                e = sb.pop_front();
                checks++;
                if (got !== e) begin
                    failures++; $display("FAIL branch%0d_cycle%0d got=%h exp=%h", k, i + 1, got, e);
                end
                if (p[i] == BRANCH) begin
                    checks++;
                    if (pc_en !== bp[k]) begin
                        failures++; $display("FAIL branch%0d_pc_en got=%b exp=%b", k, pc_en, bp[k]);
                    end
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_addi_jump();
        state_t p [9] = '{FETCH, FETCH, FETCH, DECODE, ADDIEX, ADDIWB, FETCH, DECODE, JUMP};
        logic   r [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        outs_t  e;
        funct = 6'h00; zero = 1'b0;
        for (int i = 0; i < 9; i++) begin
            op = (i < 6) ? OP_ADDI : OP_J;
            mem_ready = r[i];
            sb.push_back(exp_of(p[i], op, funct, zero, r[i], 1'b1));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin failures++; $display("FAIL addi_j_cycle%0d got=%h exp=%h", i + 1, got, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        state_t p [3] = '{FETCH, DECODE, FETCH};
        logic   r [3] = '{1'b1, 1'b1, 1'b0};
        outs_t  e;
        op = 6'b111111; funct = 6'h00; zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_ready = r[i];
            sb.push_back(exp_of(p[i], op, funct, zero, r[i], 1'b1));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin failures++; $display("FAIL illegal_cycle%0d got=%h exp=%h", i + 1, got, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bne_disabled();
        state_t p [3] = '{FETCH, DECODE, FETCH};
        logic   r [3] = '{1'b1, 1'b1, 1'b0};
        outs_t  e;
        int     pulses = 0;
        rst_nb = 1'b1;
        op = OP_BNE; funct = 6'h00; zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_ready = r[i];
            sb.push_back(exp_of(p[i], op, funct, zero, r[i], 1'b0));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (got_nb !== e) begin failures++; $display("FAIL bne_off_cycle%0d got=%h exp=%h", i + 1, got_nb, e); end
            if (illegal_n === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL bne_off_pulse got=%0d exp=1", pulses); end
        rst_nb = 1'b0;
    endtask

    task automatic test_reset_midway();
        state_t p [4] = '{FETCH, DECODE, MEMADR, MEMRD};
        logic   r [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        outs_t  e;
        op = OP_LW; funct = 6'h00; zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = r[i];
            sb.push_back(exp_of(p[i], op, funct, zero, r[i], 1'b1));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin failures++; $display("FAIL midrst_cycle%0d got=%h exp=%h", i + 1, got, e); end
            @(posedge clk); #1;
        end
        #1;
        checks++;
        if (state !== MEMRD) begin failures++; $display("FAIL midrst_hold got=%0d exp=%0d", state, MEMRD); end
        mem_ready = 1'b1;
        rst_n = 1'b0;
        sb.push_back(exp_of(FETCH, op, funct, zero, 1'b0, 1'b1));
        #1;
        e = sb.pop_front();
        checks++;
        if (got !== e) begin failures++; $display("FAIL midrst_async got=%h exp=%h", got, e); end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        test_lw();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_rtype();
        test_branch();
        test_addi_jump();
        test_illegal();
        test_bne_disabled();
        test_reset_midway();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
